// File: rtl/symbol_mapper.sv
// symbol_mapper
// -------------
// Maps a serial bit stream onto BPSK or QPSK constellation points.
//   BPSK (mode=0): one bit per symbol, I = +/-AMP, Q = 0.
//   QPSK (mode=1): two bits per symbol, first bit -> I, second bit -> Q.
// mode is sampled only when a bit is accepted in EMPTY, so a QPSK pair
// always completes as QPSK even if mode changes while half a pair is held.
//
// Optional feature: define SYMBOL_MAPPER_DIFF_EN to differentially encode
// each rail (d = b ^ prev, prev <= d when the symbol forms) before mapping.
// Without it there are no history registers and the mapping is direct.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = BPSK, 1 = QPSK
//   bit_in     in   serial data bit
//   bit_valid  in   bit_in is valid
//   bit_ready  out  block accepts a bit this cycle
//   sym_i      out  signed in-phase sample (DW bits)
//   sym_q      out  signed quadrature sample (DW bits)
//   sym_valid  out  sym_i/sym_q hold a symbol
//   sym_ready  in   downstream accepts the symbol
//   sym_cnt    out  count of delivered symbols (CW bits, wraps)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds data stable while valid=1 and ready=0, and
// valid never depends on ready. bit_ready depends combinationally on
// sym_ready so a delivered symbol can be replaced on the same edge.
module symbol_mapper #(
    parameter int DW  = 8,
    parameter int AMP = 64,
    parameter int CW  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 bit_ready,
    output logic signed [DW-1:0] sym_i,
    output logic signed [DW-1:0] sym_q,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [CW-1:0]        sym_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    localparam logic signed [DW-1:0] AMP_P = DW'(AMP);
    localparam logic signed [DW-1:0] AMP_N = -AMP_P;

    function automatic logic signed [DW-1:0] map_bit(input logic b);
        return b ? AMP_P : AMP_N;
    endfunction

    // state_q is the FSM state; it is left visible by name for checkers.
    state_t                state_q, state_d;
    logic                  b0_q, b0_d;
    logic signed [DW-1:0]  sym_i_q, sym_i_d;
    logic signed [DW-1:0]  sym_q_q, sym_q_d;
    logic                  sym_valid_q, sym_valid_d;
    logic [CW-1:0]         sym_cnt_q, sym_cnt_d;

    logic accept;
    logic deliver;
    logic hist_i;
    logic hist_q;
    logic d_i;
    logic d_q;

`ifdef SYMBOL_MAPPER_DIFF_EN
    logic prev_i_q, prev_i_d;
    logic prev_q_q, prev_q_d;
    assign hist_i = prev_i_q;
    assign hist_q = prev_q_q;
`else
    assign hist_i = 1'b0;
    assign hist_q = 1'b0;
`endif

    // A first QPSK bit never produces a symbol, so it may be taken even
    // while the output register is still occupied.
    assign bit_ready = ((state_q == EMPTY) && mode) || !sym_valid_q || sym_ready;
    assign accept    = bit_valid && bit_ready;
    assign deliver   = sym_valid_q && sym_ready;

    always_comb begin
        state_d     = state_q;
        b0_d        = b0_q;
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        sym_valid_d = sym_valid_q;
        sym_cnt_d   = sym_cnt_q;
        d_i         = 1'b0;
        d_q         = 1'b0;
`ifdef SYMBOL_MAPPER_DIFF_EN
        prev_i_d    = prev_i_q;
        prev_q_d    = prev_q_q;
`endif

        if (deliver) begin
            sym_valid_d = 1'b0;
            sym_cnt_d   = sym_cnt_q + CW'(1);
        end

        // A symbol formed here overrides the clear above, keeping
        // sym_valid high for back-to-back BPSK.
        if (accept) begin
            case (state_q)
                EMPTY: begin
                    if (mode) begin
                        b0_d    = bit_in;
                        state_d = HALF;
                    end else begin
                        d_i         = bit_in ^ hist_i;
                        sym_i_d     = map_bit(d_i);
                        sym_q_d     = '0;
                        sym_valid_d = 1'b1;
`ifdef SYMBOL_MAPPER_DIFF_EN
                        prev_i_d    = d_i;
`endif
                    end
                end
                HALF: begin
                    d_i         = b0_q ^ hist_i;
                    d_q         = bit_in ^ hist_q;
                    sym_i_d     = map_bit(d_i);
                    sym_q_d     = map_bit(d_q);
                    sym_valid_d = 1'b1;
                    state_d     = EMPTY;
`ifdef SYMBOL_MAPPER_DIFF_EN
                    prev_i_d    = d_i;
                    prev_q_d    = d_q;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            b0_q        <= 1'b0;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_valid_q <= 1'b0;
            sym_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            b0_q        <= b0_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            sym_valid_q <= sym_valid_d;
            sym_cnt_q   <= sym_cnt_d;
        end
    end

`ifdef SYMBOL_MAPPER_DIFF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_i_q <= 1'b0;
            prev_q_q <= 1'b0;
        end else begin
            prev_i_q <= prev_i_d;
            prev_q_q <= prev_q_d;
        end
    end
`endif

    assign sym_i     = sym_i_q;
    assign sym_q     = sym_q_q;
    assign sym_valid = sym_valid_q;
    assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_symbol_mapper.sv
// Testbench for symbol_mapper. Two instances share the stimulus: one with
// the default 16-bit counter and one with a 2-bit counter to see the wrap.
module tb_symbol_mapper;
  localparam int DW  = 8;
  localparam int AMP = 64;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic mode, bit_in, bit_valid, sym_ready;
  logic bit_ready, sym_valid;
  logic signed [DW-1:0] sym_i, sym_q;
  logic [15:0] sym_cnt;
  logic b_ready, b_valid;
  logic signed [DW-1:0] b_i, b_q;
  logic [1:0] b_cnt;

  symbol_mapper #(.DW(DW), .AMP(AMP), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .sym_i(sym_i),
    .sym_q(sym_q), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_cnt(sym_cnt)
  );

  symbol_mapper #(.DW(DW), .AMP(AMP), .CW(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_ready(b_ready), .sym_i(b_i),
    .sym_q(b_q), .sym_valid(b_valid), .sym_ready(sym_ready),
    .sym_cnt(b_cnt)
  );

  // scoreboard and reference model
  logic [2*DW-1:0] exp_q[$];
  logic m_half, m_b0, m_pi, m_pq;
  int   m_cnt;
  int   checks = 0;
  int   failures = 0;
  int   valid_seen = 0;
  logic last_acc;

  function automatic logic [DW-1:0] mapv(input logic b);
    logic [DW-1:0] p;
    p = DW'(AMP);
    return b ? p : -p;
  endfunction

  task automatic model_accept(input logic b, input logic md, output logic formed);
    logic di, dq;
    formed = 1'b0;
    if (!m_half) begin
      if (md) begin
        m_b0 = b;
        m_half = 1'b1;
      end else begin
        di = b;
`ifdef SYMBOL_MAPPER_DIFF_EN
        di = b ^ m_pi;
        m_pi = di;
`endif
        exp_q.push_back({mapv(di), {DW{1'b0}}});
        formed = 1'b1;
      end
    end else begin
      di = m_b0;
      dq = b;
`ifdef SYMBOL_MAPPER_DIFF_EN
      di = di ^ m_pi;
      dq = dq ^ m_pq;
      m_pi = di;
      m_pq = dq;
`endif
      exp_q.push_back({mapv(di), mapv(dq)});
      m_half = 1'b0;
      formed = 1'b1;
    end
  endtask

  // One clock of the driver/monitor loop; entered just after a negedge.
  task automatic step();
    logic acc, del, formed, exp_rdy;
    #1;
    exp_rdy = (!m_half && mode) || !sym_valid || sym_ready;
    checks++;
    if (bit_ready !== exp_rdy) begin
      failures++;
      $display("FAIL bit_ready: got %b expected %b", bit_ready, exp_rdy);
    end
    if (sym_valid === 1'b1) begin
      valid_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_symbol: got i=%0d q=%0d expected no symbol", sym_i, sym_q);
      end else if ({sym_i, sym_q} !== exp_q[0]) begin
        failures++;
        $display("FAIL symbol: got %h expected %h", {sym_i, sym_q}, exp_q[0]);
      end
    end
    acc = bit_valid && bit_ready;
    del = sym_valid && sym_ready;
    if (del && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      m_cnt++;
    end
    formed = 1'b0;
    if (acc) model_accept(bit_in, mode, formed);
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    if (del) begin
      checks += 2;
      if (sym_cnt !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL sym_cnt: got %0d expected %0d", sym_cnt, 16'(m_cnt));
      end
      if (b_cnt !== 2'(m_cnt)) begin
        failures++;
        $display("FAIL sym_cnt_cw2: got %0d expected %0d", b_cnt, 2'(m_cnt));
      end
    end
    if (formed) begin
      checks++;
      if (sym_valid !== 1'b1) begin
        failures++;
        $display("FAIL latency: got sym_valid=%b expected 1", sym_valid);
      end
    end
  endtask

  // driver tasks
  task automatic send_bits(input logic [7:0] bits, input int n, input logic md);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_in = bits[n-1-i];
      mode = md;
      last_acc = 1'b0;
      for (int t = 0; t < 20 && !last_acc; t++) step();
      if (!last_acc) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got no accept expected accept");
      end
    end
    bit_valid = 1'b0;
  endtask

  task automatic drain();
    bit_valid = 1'b0;
    sym_ready = 1'b1;
    for (int t = 0; t < 10 && (exp_q.size() > 0 || sym_valid); t++) step();
    checks++;
    if (exp_q.size() != 0 || sym_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bit_valid = 1'b0;
    #2;
    checks += 6;
    if (sym_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", sym_valid); end
    if (sym_i !== 8'sd0) begin failures++; $display("FAIL rst_i: got %0d expected 0", sym_i); end
    if (sym_q !== 8'sd0) begin failures++; $display("FAIL rst_q: got %0d expected 0", sym_q); end
    if (sym_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt: got %0d expected 0", sym_cnt); end
    if (b_cnt !== 2'd0) begin failures++; $display("FAIL rst_cnt_cw2: got %0d expected 0", b_cnt); end
    if (dut.state_q !== 1'b0) begin failures++; $display("FAIL rst_state: got %b expected EMPTY", dut.state_q); end
    exp_q.delete();
    m_half = 1'b0; m_b0 = 1'b0; m_pi = 1'b0; m_pq = 1'b0; m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    mode = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
    do_reset();
  endtask

  task automatic test_bpsk();
    sym_ready = 1'b1;
    send_bits(8'b101, 3, 1'b0);
    drain();
    checks++;
    if (sym_cnt !== 16'd3) begin
      failures++;
      $display("FAIL bpsk_cnt: got %0d expected 3", sym_cnt);
    end
  endtask

  task automatic test_qpsk();
    int v0;
    sym_ready = 1'b1;
    v0 = valid_seen;
    send_bits(8'b1001, 4, 1'b1);
    drain();
    checks++;
    if (valid_seen - v0 != 2) begin
      failures++;
      $display("FAIL qpsk_valid_count: got %0d expected 2", valid_seen - v0);
    end
  endtask

  task automatic test_back_to_back_hold();
    sym_ready = 1'b0;
    send_bits(8'b1, 1, 1'b0);
    bit_valid = 1'b1; bit_in = 1'b0; mode = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step();
      checks++;
      if (bit_ready !== 1'b0 || sym_valid !== 1'b1) begin
        failures++;
        $display("FAIL hold: got ready=%b valid=%b expected ready=0 valid=1", bit_ready, sym_valid);
      end
    end
    sym_ready = 1'b1;
    step();
    checks++;
    if (last_acc !== 1'b1) begin
      failures++;
      $display("FAIL release_accept: got %b expected 1", last_acc);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int v0;
    sym_ready = 1'b1;
    send_bits(8'b1, 1, 1'b1);
    @(negedge clk);
    do_reset();
    v0 = valid_seen;
    send_bits(8'b01, 2, 1'b1);
    drain();
    checks++;
    if (valid_seen - v0 != 1) begin
      failures++;
      $display("FAIL reset_mid_count: got %0d expected 1", valid_seen - v0);
    end
  endtask

  task automatic test_diff();
    do_reset();
    sym_ready = 1'b1;
    send_bits(8'b110, 3, 1'b0);
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    sym_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_bits(8'($urandom_range(0, 1)), 1, 1'b0);
    drain();
    checks++;
    if (b_cnt !== 2'd1) begin
      failures++;
      $display("FAIL wrap_final: got %0d expected 1", b_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      mode      = 1'($urandom_range(0, 1));
      sym_ready = 1'($urandom_range(0, 1));
      step();
    end
    // finish any half pair so nothing is left pending
    if (m_half) send_bits(8'b1, 1, 1'b0);
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    bit_valid = 1'b0;
    test_reset();
    test_bpsk();
    test_qpsk();
    test_back_to_back_hold();
    test_reset_mid();
    test_diff();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/symbol_mapper.md
SYMBOL_MAPPER -- requirements
Module: symbol_mapper

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the signed I/Q sample width.
REQ-002 The block SHALL have parameter AMP, default 64, giving the constellation magnitude; legal range 1..2^(DW-1)-1.
REQ-003 The block SHALL have parameter CW, default 16, giving the symbol counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 selects BPSK, 1 selects QPSK.
REQ-007 The block SHALL have port bit_in, input, 1 bit: serial data bit.
REQ-008 The block SHALL have port bit_valid, input, 1 bit: bit_in is valid.
REQ-009 The block SHALL have port bit_ready, output, 1 bit: the block accepts a bit this cycle.
REQ-010 The block SHALL have port sym_i, output, DW bits, signed: in-phase sample.
REQ-011 The block SHALL have port sym_q, output, DW bits, signed: quadrature sample.
REQ-012 The block SHALL have port sym_valid, output, 1 bit: sym_i/sym_q hold a symbol.
REQ-013 The block SHALL have port sym_ready, input, 1 bit: the downstream block accepts the symbol.
REQ-014 The block SHALL have port sym_cnt, output, CW bits: count of symbols delivered.

Function
REQ-015 A bit SHALL be accepted on any cycle where bit_valid and bit_ready are both 1; a symbol SHALL be delivered on any cycle where sym_valid and sym_ready are both 1.
REQ-016 The state machine SHALL have state EMPTY (no partial symbol held) and state HALF (first QPSK bit held).
REQ-017 mode SHALL be sampled only on a bit accepted in EMPTY; a mode change while in HALF SHALL take effect at the next symbol boundary.
REQ-018 In BPSK, an accepted bit b SHALL form one symbol: I = +AMP if b=1, -AMP if b=0; Q = 0; the state SHALL remain EMPTY.
REQ-019 In QPSK, the first accepted bit b0 SHALL be stored and SHALL move the state EMPTY->HALF.
REQ-020 In QPSK, the second accepted bit b1 SHALL form the symbol I = (b0 ? +AMP : -AMP), Q = (b1 ? +AMP : -AMP), and SHALL move the state HALF->EMPTY.
REQ-021 A formed symbol SHALL appear on sym_i/sym_q with sym_valid=1 on the cycle after the accepting edge (latency 1 cycle).
REQ-022 bit_ready SHALL be 1 when (state=EMPTY and mode=1), or when sym_valid=0, or when sym_ready=1; it SHALL depend combinationally on sym_ready.
REQ-023 A symbol delivered and a new symbol formed on the same edge SHALL load the new symbol with sym_valid held at 1, giving back-to-back throughput of 1 symbol per cycle in BPSK.
REQ-024 While sym_valid=1 and sym_ready=0, sym_i and sym_q SHALL stay stable.
REQ-025 Values of bit_in SHALL be ignored while bit_valid=0.
REQ-026 sym_cnt SHALL increment by 1 on each delivered symbol and SHALL wrap from 2^CW-1 to 0.
REQ-027 Magnitudes SHALL be sign-extended to DW bits as two's complement; -AMP SHALL never saturate.

Reset
REQ-028 While rst_n=0, the block SHALL force: state=EMPTY; sym_valid=0; sym_i=0; sym_q=0; sym_cnt=0; stored bit=0; differential history=0.
REQ-029 Reset asserted mid-operation SHALL discard a held partial QPSK bit and any undelivered symbol; no output SHALL be produced for them after release.
REQ-030 The first bit SHALL be accepted no earlier than the first rising clk edge after rst_n deasserts.

Configuration
REQ-031 With macro SYMBOL_MAPPER_DIFF_EN defined, the block SHALL apply differential encoding per rail before mapping: d = b XOR prev, with prev updated to d when the symbol forms (the BPSK rail uses the I history; QPSK uses separate I and Q histories).
REQ-032 With SYMBOL_MAPPER_DIFF_EN undefined, mapping SHALL be direct and no history registers SHALL exist.

Verification
REQ-033 The bench SHALL cover: DW=8, AMP=64, mode=0, bits 1,0,1 with sym_ready=1 -> (I,Q) = (64,0), (-64,0), (64,0) on consecutive cycles, and sym_cnt=3.
REQ-034 The bench SHALL cover: mode=1, bits 1,0,0,1 -> (64,-64), (-64,64), with sym_valid=1 only once per bit pair.
REQ-035 The bench SHALL cover: sym_ready=0 with BPSK bit 1 output -> the symbol holds at (64,0), bit_ready=0; after sym_ready=1, delivery occurs and the next bit is accepted on the same cycle.
REQ-036 The bench SHALL cover: mode=1, one bit accepted, then rst_n pulsed low -> state=EMPTY, sym_valid=0; the next two bits form a fresh symbol.
REQ-037 The bench SHALL cover: with SYMBOL_MAPPER_DIFF_EN, mode=0, bits 1,1,0 -> I = 64, -64, -64.
REQ-038 The bench SHALL cover: CW=2, 5 symbols delivered -> sym_cnt sequence 1,2,3,0,1.
